// File: rtl/pong_pkg.sv
// Shared constants and types for the pong input front-end.
// Bit indices follow the btn_raw pin order.
package pong_pkg;

    localparam int unsigned NUM_BTN  = 5;
    localparam int unsigned BTN_L_UP = 0;
    localparam int unsigned BTN_L_DN = 1;
    localparam int unsigned BTN_R_UP = 2;
    localparam int unsigned BTN_R_DN = 3;
    localparam int unsigned BTN_RST  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// One push-button lane: 2-flop synchroniser, tick-based debounce and a
// press / auto-repeat pulse generator. o_level and o_pulse update on the same edge.
module button_channel
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS     = 8,
    parameter int unsigned REPEAT_DELAY_TICKS = 300,
    parameter int unsigned REPEAT_TICKS       = 10,
    parameter bit          REPEAT_EN          = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned RC_MAX = (REPEAT_DELAY_TICKS > REPEAT_TICKS) ?
                                     REPEAT_DELAY_TICKS : REPEAT_TICKS;
    localparam int unsigned RC_W   = $clog2(RC_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [RC_W-1:0] RT_LAST = RC_W'(REPEAT_TICKS - 1);

    logic [1:0]      r_sync;
    logic            r_level;
    logic [DB_W-1:0] r_cnt;
    btn_state_t      r_state;
    logic [RC_W-1:0] r_rcnt;
    logic            r_pulse;

    logic w_s;
    logic w_diff;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    assign w_s    = r_sync[1];
    assign w_diff = w_s ^ r_level;
    assign w_flip = w_diff & i_tick & (r_cnt == DB_LAST);
    assign w_rise = w_flip & w_s;
    assign w_fall = w_flip & ~w_s;

    // Synchroniser and debounce counter; any clk where s matches level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else if (i_tick) begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    // Press / repeat FSM; a release takes priority over any repeat due on the same tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_fall) begin
                r_state <= IDLE;
                r_rcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_pulse <= 1'b1;
                            r_rcnt  <= '0;
                            r_state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (i_tick && REPEAT_EN) begin
                            if (r_rcnt == RD_LAST) begin
                                r_pulse <= 1'b1;
                                r_rcnt  <= '0;
                                r_state <= REPEAT;
                            end else begin
                                r_rcnt <= r_rcnt + RC_W'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        if (i_tick) begin
                            if (r_rcnt == RT_LAST) begin
                                r_pulse <= 1'b1;
                                r_rcnt  <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + RC_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/pong_input_conditioner.sv
// Conditions the five pong push-buttons into debounced levels and press/repeat
// pulses; opposing buttons of one paddle held together emit no pulses.
module pong_input_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned TICK_DIV           = 25175,
    parameter int unsigned DEBOUNCE_TICKS     = 8,
    parameter int unsigned REPEAT_DELAY_TICKS = 300,
    parameter int unsigned REPEAT_TICKS       = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pressed,
    output logic               tick
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_PRE  = PS_W'(TICK_DIV - 2);

    logic [PS_W-1:0]    r_ps;
    logic               r_tick;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_pulse;
    logic [NUM_BTN-1:0] w_conflict;

    // Prescaler; r_tick is set one clk early so it is high exactly while r_ps == TICK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps   <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_ps == PS_PRE);
            if (r_ps == PS_LAST) begin
                r_ps <= '0;
            end else begin
                r_ps <= r_ps + PS_W'(1);
            end
        end
    end

    assign tick = r_tick;

    for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
            .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
            .REPEAT_TICKS       (REPEAT_TICKS),
            .REPEAT_EN          ((g == int'(BTN_RST)) ? 1'b0 : 1'b1)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (r_tick),
            .i_raw   (btn_raw[g]),
            .o_level (w_level[g]),
            .o_pulse (w_pulse[g])
        );
    end

    // Up+down on the same paddle held together cancels both pulses.
    always_comb begin
        w_conflict           = '0;
        w_conflict[BTN_L_UP] = w_level[BTN_L_UP] & w_level[BTN_L_DN];
        w_conflict[BTN_L_DN] = w_level[BTN_L_UP] & w_level[BTN_L_DN];
        w_conflict[BTN_R_UP] = w_level[BTN_R_UP] & w_level[BTN_R_DN];
        w_conflict[BTN_R_DN] = w_level[BTN_R_UP] & w_level[BTN_R_DN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level   <= '0;
            btn_pressed <= '0;
        end else begin
            btn_level   <= w_level;
            btn_pressed <= w_pulse & ~w_conflict;
        end
    end

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Directed bench for pong_input_conditioner with small prescaler/debounce/repeat values.
// Sample k is taken 1 time unit after the k-th rising edge following reset release.
module tb_pong_input_conditioner;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned RDLY     = 5;
    localparam int unsigned RPT      = 2;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pressed;
    logic       tick;

    int n_checks;
    int n_fail;

    pong_input_conditioner #(
        .TICK_DIV           (TICK_DIV),
        .DEBOUNCE_TICKS     (DEB),
        .REPEAT_DELAY_TICKS (RDLY),
        .REPEAT_TICKS       (RPT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_pressed (btn_pressed),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        int cnt4;
        int cntlo;
        rst     = 1'b1;
        btn_raw = 5'h1F;
        repeat (3) step();
        n_checks++;
        if (btn_level !== 5'h00) begin
            n_fail++;
            $display("FAIL reset_level: got %h expected %h", btn_level, 5'h00);
        end
        n_checks++;
        if (btn_pressed !== 5'h00) begin
            n_fail++;
            $display("FAIL reset_pressed: got %h expected %h", btn_pressed, 5'h00);
        end
        n_checks++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b expected 0", tick);
        end
        rst   = 1'b0;
        first = -1;
        cnt4  = 0;
        cntlo = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (btn_pressed[4]) cnt4++;
            cntlo += int'($countones(btn_pressed[3:0]));
            if (first < 0 && btn_pressed != 5'h00) first = k;
            if (k == 13) begin
                n_checks++;
                if (btn_pressed !== 5'h10) begin
                    n_fail++;
                    $display("FAIL reset_first_pulse: got %h expected %h", btn_pressed, 5'h10);
                end
                n_checks++;
                if (btn_level !== 5'h1F) begin
                    n_fail++;
                    $display("FAIL reset_first_level: got %h expected %h", btn_level, 5'h1F);
                end
            end
        end
        n_checks++;
        if (first != 13) begin
            n_fail++;
            $display("FAIL reset_latency: got %0d expected 13", first);
        end
        n_checks++;
        if (cnt4 != 1) begin
            n_fail++;
            $display("FAIL reset_bit4_count: got %0d expected 1", cnt4);
        end
        n_checks++;
        if (cntlo != 0) begin
            n_fail++;
            $display("FAIL reset_pair_pulses: got %0d expected 0", cntlo);
        end
        // asynchronous assertion between clock edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (btn_level !== 5'h00) begin
            n_fail++;
            $display("FAIL async_reset_level: got %h expected %h", btn_level, 5'h00);
        end
        btn_raw = '0;
    endtask

    task automatic test_prescaler();
        do_reset();
        n_checks++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_k0: got %b expected 0", tick);
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            n_checks++;
            if (tick !== ((k % 4) == 3)) begin
                n_fail++;
                $display("FAIL tick_k%0d: got %b expected %b", k, tick, ((k % 4) == 3));
            end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] exp;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = ~btn_raw[0];
            for (int j = 0; j < 6; j++) begin
                step();
                n_checks++;
                if (btn_pressed[0] !== 1'b0 || btn_level[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_glitch: got level=%b pressed=%b expected 0/0 at k=%0d",
                             btn_level[0], btn_pressed[0], i * 6 + j + 1);
                end
            end
        end
        btn_raw[0] = 1'b1;
        for (int k = 61; k <= 90; k++) begin
            step();
            exp = {1'b0, 1'b0};
            exp[1] = (k >= 73);
            exp[0] = (k == 73);
            n_checks++;
            if ({btn_level[0], btn_pressed[0]} !== exp) begin
                n_fail++;
                $display("FAIL bounce_settle: got level/pressed=%b expected %b at k=%0d",
                         {btn_level[0], btn_pressed[0]}, exp, k);
            end
        end
        btn_raw = '0;
    endtask

    task automatic test_auto_repeat();
        logic exp;
        int   cnt;
        do_reset();
        btn_raw[2] = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 160; k++) begin
            step();
            exp = (k == 13) || (k >= 33 && k <= 89 && ((k - 33) % 8) == 0);
            if (btn_pressed[2]) cnt++;
            n_checks++;
            if (btn_pressed !== {2'b00, exp, 2'b00}) begin
                n_fail++;
                $display("FAIL repeat_pulse: got %h expected %h at k=%0d",
                         btn_pressed, {2'b00, exp, 2'b00}, k);
            end
            if (k == 92 || k == 93) begin
                n_checks++;
                if (btn_level[2] !== (k == 92)) begin
                    n_fail++;
                    $display("FAIL repeat_release_level: got %b expected %b at k=%0d",
                             btn_level[2], (k == 92), k);
                end
            end
            if (k == 81) btn_raw[2] = 1'b0;
        end
        n_checks++;
        if (cnt != 9) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d expected 9", cnt);
        end
    endtask

    task automatic test_score_reset();
        int cnt;
        do_reset();
        btn_raw[4] = 1'b1;
        cnt = 0;
        repeat (200) begin
            step();
            if (btn_pressed[4]) cnt++;
        end
        n_checks++;
        if (cnt != 1 || btn_level[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL score_hold: got count=%0d level=%b expected 1/1", cnt, btn_level[4]);
        end
        btn_raw[4] = 1'b0;
        cnt = 0;
        repeat (30) begin
            step();
            if (btn_pressed[4]) cnt++;
        end
        n_checks++;
        if (cnt != 0 || btn_level[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL score_release: got count=%0d level=%b expected 0/0", cnt, btn_level[4]);
        end
        btn_raw[4] = 1'b1;
        cnt = 0;
        repeat (40) begin
            step();
            if (btn_pressed[4]) cnt++;
        end
        n_checks++;
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL score_second_press: got %0d expected 1", cnt);
        end
        btn_raw = '0;
    endtask

    task automatic test_conflict();
        logic [4:0] exp;
        do_reset();
        btn_raw = 5'b00101;
        for (int k = 1; k <= 80; k++) begin
            step();
            exp    = '0;
            exp[0] = (k inside {13, 49, 57, 65, 73});
            exp[2] = (k == 13) || (k >= 33 && ((k - 33) % 8) == 0);
            n_checks++;
            if (btn_pressed !== exp) begin
                n_fail++;
                $display("FAIL conflict_pulse: got %h expected %h at k=%0d", btn_pressed, exp, k);
            end
            if (k == 30) begin
                n_checks++;
                if (btn_level !== 5'b00111) begin
                    n_fail++;
                    $display("FAIL conflict_level_both: got %h expected %h", btn_level, 5'b00111);
                end
            end
            if (k == 60) begin
                n_checks++;
                if (btn_level !== 5'b00101) begin
                    n_fail++;
                    $display("FAIL conflict_level_after: got %h expected %h", btn_level, 5'b00101);
                end
            end
            if (k == 8)  btn_raw[1] = 1'b1;
            if (k == 36) btn_raw[1] = 1'b0;
        end
        btn_raw = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        btn_raw  = '0;
        test_reset();
        test_prescaler();
        test_bounce();
        test_auto_repeat();
        test_score_reset();
        test_conflict();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
